card_game_ctrl: RTL and testbench

CARD_GAME_CTRL -- requirements
Module: card_game_ctrl

---
 rtl/card_pkg.sv | 30 +++
 rtl/card_game_ctrl_hold_timer.sv | 32 +++
 rtl/card_game_ctrl.sv | 146 ++++++++++++++
 tb/tb_card_game_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared constants, FSM encodings and slot helpers for the memory card game.
package card_pkg;

  localparam int unsigned NUM_SLOTS    = 16;
  localparam int unsigned NUM_PAIRS    = 8;
  localparam int unsigned ATTEMPTS_MAX = 255;
  localparam int unsigned IDX_W        = 4;
  localparam int unsigned PAIR_W       = 3;
  localparam int unsigned SCORE_W      = 4;
  localparam int unsigned ATT_W        = 8;
  localparam int unsigned CARD_W       = 4 * NUM_SLOTS;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FIRST = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_SHOW  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Pair id of a slot: bits [3:1] of its 4-bit card id.
  function automatic logic [PAIR_W-1:0] pair_of(input logic [CARD_W-1:0] ids,
                                                input logic [IDX_W-1:0]  idx);
    pair_of = ids[{idx, 2'b01} +: PAIR_W];
  endfunction

  // One-hot mask for a slot index.
  function automatic logic [NUM_SLOTS-1:0] slot_bit(input logic [IDX_W-1:0] idx);
    slot_bit = NUM_SLOTS'(1) << idx;
  endfunction

endpackage

// File: rtl/card_game_ctrl_hold_timer.sv
// Down-counter that holds a mismatched pair face-up for SHOW_CYCLES cycles.
module hold_timer #(
  parameter int unsigned SHOW_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  output logic done_c
);

  localparam int unsigned CNT_W = $clog2(SHOW_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Load with the hold length, then count down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(SHOW_CYCLES);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  // Last hold cycle: caller leaves SHOW on this edge.
  assign done_c = (count == CNT_W'(1));

endmodule

// File: rtl/card_game_ctrl.sv
// Memory card game controller: two-card flip, compare, hold on mismatch, score.
module card_game_ctrl
  import card_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES = 50_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 restart,
  input  logic                 sel_valid,
  input  logic [IDX_W-1:0]     sel_idx,
  input  logic [CARD_W-1:0]    card_id,
  output logic [NUM_SLOTS-1:0] reg_card,
  output logic [NUM_SLOTS-1:0] matched,
  output logic [SCORE_W-1:0]   score,
  output logic [ATT_W-1:0]     attempts,
  output logic                 busy,
  output logic                 game_over
);

  logic [2:0]           state, state_d;
  logic [IDX_W-1:0]     first_idx, first_d, second_idx, second_d;
  logic                 up_first, up_first_d, up_second, up_second_d;
  logic [NUM_SLOTS-1:0] matched_d, reg_card_d;
  logic [SCORE_W-1:0]   score_d;
  logic [ATT_W-1:0]     attempts_d;
  logic                 busy_d, game_over_d;
  logic                 armed;
  logic                 sel_ok, timer_load, timer_clear, timer_done_c;

  hold_timer #(.SHOW_CYCLES(SHOW_CYCLES)) u_hold_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .load   (timer_load),
    .done_c (timer_done_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    first_d     = first_idx;
    second_d    = second_idx;
    up_first_d  = up_first;
    up_second_d = up_second;
    matched_d   = matched;
    score_d     = score;
    attempts_d  = attempts;
    timer_load  = 1'b0;
    timer_clear = 1'b0;

    sel_ok = armed && sel_valid && ((state == ST_IDLE) || (state == ST_FIRST)) &&
             !matched[sel_idx] && !reg_card[sel_idx];

    if (armed && restart) begin
      state_d     = ST_IDLE;
      up_first_d  = 1'b0;
      up_second_d = 1'b0;
      matched_d   = '0;
      score_d     = '0;
      attempts_d  = '0;
      timer_clear = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel_ok) begin
            first_d    = sel_idx;
            up_first_d = 1'b1;
            state_d    = ST_FIRST;
          end
        end
        ST_FIRST: begin
          if (sel_ok) begin
            second_d    = sel_idx;
            up_second_d = 1'b1;
            state_d     = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (attempts != ATT_W'(ATTEMPTS_MAX)) attempts_d = attempts + ATT_W'(1);
          if (pair_of(card_id, first_idx) == pair_of(card_id, second_idx)) begin
            matched_d   = matched | slot_bit(first_idx) | slot_bit(second_idx);
            score_d     = score + SCORE_W'(1);
            up_first_d  = 1'b0;
            up_second_d = 1'b0;
            state_d     = (score_d == SCORE_W'(NUM_PAIRS)) ? ST_DONE : ST_IDLE;
          end else begin
            timer_load = 1'b1;
            state_d    = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (timer_done_c) begin
            up_first_d  = 1'b0;
            up_second_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    reg_card_d = matched_d |
                 (up_first_d  ? slot_bit(first_d)  : '0) |
                 (up_second_d ? slot_bit(second_d) : '0);
    busy_d      = (state_d == ST_CHECK) || (state_d == ST_SHOW);
    game_over_d = (state_d == ST_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      first_idx  <= '0;
      second_idx <= '0;
      up_first   <= 1'b0;
      up_second  <= 1'b0;
      matched    <= '0;
      score      <= '0;
      attempts   <= '0;
      reg_card   <= '0;
      busy       <= 1'b0;
      game_over  <= 1'b0;
      armed      <= 1'b0;
    end else begin
      state      <= state_d;
      first_idx  <= first_d;
      second_idx <= second_d;
      up_first   <= up_first_d;
      up_second  <= up_second_d;
      matched    <= matched_d;
      score      <= score_d;
      attempts   <= attempts_d;
      reg_card   <= reg_card_d;
      busy       <= busy_d;
      game_over  <= game_over_d;
      armed      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_card_game_ctrl.sv
// Directed bench for card_game_ctrl with slot i holding card id i, hold of 4 cycles.
module tb_card_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        restart;
  logic        sel_valid;
  logic [3:0]  sel_idx;
  logic [63:0] card_id;
  logic [15:0] reg_card;
  logic [15:0] matched;
  logic [3:0]  score;
  logic [7:0]  attempts;
  logic        busy;
  logic        game_over;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rs;
    logic        sv;
    logic [3:0]  idx;
    logic [15:0] e_reg;
    logic [15:0] e_mat;
    logic [3:0]  e_score;
    logic [7:0]  e_att;
    logic        e_busy;
    logic        e_over;
  } vec_t;

  vec_t vecs[$];

  card_game_ctrl #(.SHOW_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart   (restart),
    .sel_valid (sel_valid),
    .sel_idx   (sel_idx),
    .card_id   (card_id),
    .reg_card  (reg_card),
    .matched   (matched),
    .score     (score),
    .attempts  (attempts),
    .busy      (busy),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] r, input logic [15:0] m,
                         input logic [3:0] s, input logic [7:0] a, input logic b,
                         input logic o);
    chk({tag, ".reg_card"}, reg_card, r);
    chk({tag, ".matched"}, matched, m);
    chk({tag, ".score"}, 16'(score), 16'(s));
    chk({tag, ".attempts"}, 16'(attempts), 16'(a));
    chk({tag, ".busy"}, 16'(busy), 16'(b));
    chk({tag, ".game_over"}, 16'(game_over), 16'(o));
  endtask

  // One clock with the given inputs; outputs settled 1 time unit after the edge.
  task automatic step(input logic rs, input logic sv, input logic [3:0] idx);
    restart   = rs;
    sel_valid = sv;
    sel_idx   = idx;
    @(posedge clk);
    #1;
    restart   = 1'b0;
    sel_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_m;
    rst_n     = 1'b0;
    restart   = 1'b0;
    sel_valid = 1'b0;
    sel_idx   = 4'd0;
    card_id   = 64'hFEDC_BA98_7654_3210;

    // reset state
    #12;
    chk_all("reset", 16'h0000, 16'h0000, 4'd0, 8'd0, 1'b0, 1'b0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    // rs sv idx | reg mat score att busy over
    vecs.push_back('{1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 4'd0, 8'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd0, 16'h0001, 16'h0000, 4'd0, 8'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd2, 16'h0005, 16'h0000, 4'd0, 8'd0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0, 16'h0005, 16'h0000, 4'd0, 8'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd5, 16'h0005, 16'h0000, 4'd0, 8'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0, 16'h0005, 16'h0000, 4'd0, 8'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0, 16'h0005, 16'h0000, 4'd0, 8'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 4'd0, 8'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd0, 16'h0001, 16'h0000, 4'd0, 8'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd0, 16'h0001, 16'h0000, 4'd0, 8'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd1, 16'h0003, 16'h0000, 4'd0, 8'd1, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0, 16'h0003, 16'h0003, 4'd1, 8'd2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd0, 16'h0003, 16'h0003, 4'd1, 8'd2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd3, 16'h000B, 16'h0003, 4'd1, 8'd2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd3, 16'h000B, 16'h0003, 4'd1, 8'd2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd2, 16'h000F, 16'h0003, 4'd1, 8'd2, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0, 16'h000F, 16'h000F, 4'd2, 8'd3, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd4, 16'h001F, 16'h000F, 4'd2, 8'd3, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd6, 16'h005F, 16'h000F, 4'd2, 8'd3, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0, 16'h005F, 16'h000F, 4'd2, 8'd4, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'd7, 16'h0000, 16'h0000, 4'd0, 8'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000, 4'd0, 8'd0, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      step(vecs[i].rs, vecs[i].sv, vecs[i].idx);
      chk_all($sformatf("vec%0d", i), vecs[i].e_reg, vecs[i].e_mat, vecs[i].e_score,
              vecs[i].e_att, vecs[i].e_busy, vecs[i].e_over);
    end

    // full game: solve every pair in order
    step(1'b1, 1'b0, 4'd0);
    exp_m = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 4'(2 * k));
      step(1'b0, 1'b1, 4'(2 * k + 1));
      step(1'b0, 1'b0, 4'd0);
      exp_m = exp_m | (16'h0003 << (2 * k));
      chk_all($sformatf("game%0d", k), exp_m, exp_m, 4'(k + 1), 8'(k + 1), 1'b0,
              (k == 7) ? 1'b1 : 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 4'(5 * k));
      step(1'b0, 1'b0, 4'd0);
      chk_all($sformatf("done_hold%0d", k), 16'hFFFF, 16'hFFFF, 4'd8, 8'd8, 1'b0, 1'b1);
    end

    // attempts saturate at 255
    step(1'b1, 1'b0, 4'd0);
    chk_all("restart_done", 16'h0000, 16'h0000, 4'd0, 8'd0, 1'b0, 1'b0);
    for (int k = 0; k < 256; k++) begin
      step(1'b0, 1'b1, 4'd0);
      step(1'b0, 1'b1, 4'd2);
      for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 4'd0);
      if (k == 254) chk("att_at_255", 16'(attempts), 16'd255);
    end
    chk_all("att_sat", 16'h0000, 16'h0000, 4'd0, 8'd255, 1'b0, 1'b0);

    // asynchronous reset mid-FIRST, then inputs held across release are ignored
    step(1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 4'd0);
    chk("pre_async.reg_card", reg_card, 16'h0001);
    #3 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 16'h0000, 16'h0000, 4'd0, 8'd0, 1'b0, 1'b0);
    sel_valid = 1'b1;
    sel_idx   = 4'd4;
    restart   = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ignore.reg_card", reg_card, 16'h0000);
    sel_valid = 1'b0;
    step(1'b0, 1'b1, 4'd4);
    chk("post_rst_sel.reg_card", reg_card, 16'h0010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
